// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: raster window/tap sequencer for a strided KxK conv layer (optional CONV_SEQ_STALL_CNT_EN stall counter)
module conv_window_sequencer #(
  parameter int W_IN       = 256,
  parameter int H_IN       = 256,
  parameter int CHIN       = 3,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 2,
  parameter int PIPE_LAT   = 2,
  parameter int ADDR_W     = 18,
  parameter int TAP_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] img_addr,
  output logic [TAP_W-1:0]  wt_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              ofm_valid,
  input  logic              ofm_ready,
  output logic [7:0]        ofm_row,
  output logic [7:0]        ofm_col,
  output logic              busy,
  output logic              layer_done
`ifdef CONV_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int OUT_W = (W_IN - KERNEL_DIM) / STRIDE + 1;
  localparam int OUT_H = (H_IN - KERNEL_DIM) / STRIDE + 1;
  localparam int NT    = CHIN * KERNEL_DIM * KERNEL_DIM;
  localparam int CW    = $clog2(CHIN + 1);
  localparam int KW    = $clog2(KERNEL_DIM + 1);
  localparam int DW    = $clog2(PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0] PLANE = ADDR_W'(W_IN * H_IN);
  localparam logic [ADDR_W-1:0] ROWSZ = ADDR_W'(W_IN);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(STRIDE);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0]    ch;
  logic [KW-1:0]    ky, kx;
  logic [TAP_W-1:0] tap;
  logic [DW-1:0]    dcnt;
  logic [7:0]       row, col;
  logic go, last_tap, last_win, xfer, kx_wrap, ky_wrap;
  always_comb begin
    go         = start && (state == IDLE || state == DONE);
    last_tap   = tap == TAP_W'(NT - 1);
    last_win   = row == 8'(OUT_H - 1) && col == 8'(OUT_W - 1);
    xfer       = state == EMIT && ofm_ready;
    kx_wrap    = kx == KW'(KERNEL_DIM - 1);
    ky_wrap    = kx_wrap && ky == KW'(KERNEL_DIM - 1);
    state_nx   = go ? FETCH
               : (state == FETCH && last_tap) ? DRAIN
               : (state == DRAIN && dcnt == DW'(PIPE_LAT - 1)) ? EMIT
               : xfer ? (last_win ? DONE : FETCH)
               : state;
    mac_en     = state == FETCH;
    mac_clr    = mac_en && tap == '0;
    ofm_valid  = state == EMIT;
    busy       = state == FETCH || state == DRAIN || state == EMIT;
    layer_done = state == DONE;
    wt_addr    = mac_en ? tap : '0;
    img_addr   = mac_en ? ADDR_W'(ch) * PLANE + (ADDR_W'(row) * STEP + ADDR_W'(ky)) * ROWSZ
                          + ADDR_W'(col) * STEP + ADDR_W'(kx) : '0;
    ofm_row    = row;
    ofm_col    = col;
  end
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  // Tap counters wrap to zero on the last tap, so each window starts clean.
  always_ff @(posedge clk)
    if (!rst || go) begin
      ch   <= '0;
      ky   <= '0;
      kx   <= '0;
      tap  <= '0;
      dcnt <= '0;
      row  <= '0;
      col  <= '0;
    end else begin
      if (state == FETCH) begin
        tap <= last_tap ? '0 : tap + 1'b1;
        kx  <= kx_wrap ? '0 : kx + 1'b1;
        ky  <= kx_wrap ? (ky_wrap ? '0 : ky + 1'b1) : ky;
        ch  <= ky_wrap ? (ch == CW'(CHIN - 1) ? '0 : ch + 1'b1) : ch;
      end
      dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (xfer && !last_win) begin
        col <= col == 8'(OUT_W - 1) ? '0 : col + 1'b1;
        row <= col == 8'(OUT_W - 1) ? row + 1'b1 : row;
      end
    end
`ifdef CONV_SEQ_STALL_CNT_EN
  always_ff @(posedge clk)
    if (!rst || go) stall_cnt <= '0;
    else if (state == EMIT && !ofm_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule
